// File: rtl/core_pkg.sv
// Shared core definitions: fetch sequencer states, the canonical NOP and the
// base RV32I opcode values used by both the fetch unit and the control decoder.
package core_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } fetch_state_e;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch unit.
//   pc       : current PC
//   redirect : branch taken or unconditional jump
//   target   : redirect target from the datapath
//   pc_nxt   : target with bits [1:0] forced to zero on redirect, else pc+4 (wraps)
//   misalign : redirect target was not word aligned
module pc_next (
   input  logic [31:0] pc,
   input  logic        redirect,
   input  logic [31:0] target,
   output logic [31:0] pc_nxt,
   output logic        misalign
);

   always_comb begin
      pc_nxt   = pc + 32'd4;
      misalign = 1'b0;
      if (redirect) begin
         pc_nxt   = {target[31:2], 2'b00};
         misalign = (target[1:0] != 2'b00);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, runs the instruction-memory
// request handshake and holds the fetched instruction until the core retires it.
// One instruction in flight, no prefetch.
//   clk, reset                 : clock, synchronous active-high reset
//   imem_req/addr/rdata/ready  : instruction memory read handshake
//   retire_i                   : core finished the current instruction
//   branch_i, pc_update_i      : redirect request (taken branch / jump)
//   target_i                   : redirect target
//   instr_o + field slices     : instruction register and decoder fields
//   pc_o, pc_plus4_o           : address of instr_o and link value
//   instr_valid_o              : instr_o awaiting retire
//   misalign_o                 : sticky misaligned-redirect flag
//   instret_o                  : retired instruction count
//
// state | meaning
// BOOT  | one idle cycle after reset, outputs at reset values
// FETCH | imem_req high at pc_o, waiting for imem_ready
// ISSUE | instr_o valid, waiting for retire_i to pick the next PC
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter logic [31:0] NOP      = NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        retire_i,
   input  logic        branch_i,
   input  logic        pc_update_i,
   input  logic [31:0] target_i,
   output logic [31:0] instr_o,
   output logic [6:0]  opcode_o,
   output logic [2:0]  funct3_o,
   output logic [6:0]  funct7_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        instr_valid_o,
   output logic        misalign_o,
   output logic [31:0] instret_o
);

   fetch_state_e state;
   logic [31:0]  pc_nxt;
   logic         redirect_misalign;

   pc_next u_pc_next (
      .pc       (pc_o),
      .redirect (branch_i | pc_update_i),
      .target   (target_i),
      .pc_nxt   (pc_nxt),
      .misalign (redirect_misalign)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_BOOT;
         pc_o          <= RESET_PC;
         instr_o       <= NOP;
         instr_valid_o <= 1'b0;
         imem_req      <= 1'b0;
         misalign_o    <= 1'b0;
         instret_o     <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  instr_o       <= imem_rdata;
                  instr_valid_o <= 1'b1;
                  imem_req      <= 1'b0;
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (retire_i) begin
                  pc_o          <= pc_nxt;
                  misalign_o    <= misalign_o | redirect_misalign;
                  instret_o     <= instret_o + 32'd1;
                  instr_valid_o <= 1'b0;
                  imem_req      <= 1'b1;
                  state         <= ST_FETCH;
               end
            end
            default: begin
               state         <= ST_BOOT;
               instr_valid_o <= 1'b0;
               imem_req      <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr  = pc_o;
   assign opcode_o   = instr_o[6:0];
   assign funct3_o   = instr_o[14:12];
   assign funct7_o   = instr_o[31:25];
   assign pc_plus4_o = pc_o + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        retire_i;
   logic        branch_i;
   logic        pc_update_i;
   logic [31:0] target_i;
   logic [31:0] instr_o;
   logic [6:0]  opcode_o;
   logic [2:0]  funct3_o;
   logic [6:0]  funct7_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        instr_valid_o;
   logic        misalign_o;
   logic [31:0] instret_o;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOPV   = 32'h0000_0013;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .retire_i      (retire_i),
      .branch_i      (branch_i),
      .pc_update_i   (pc_update_i),
      .target_i      (target_i),
      .instr_o       (instr_o),
      .opcode_o      (opcode_o),
      .funct3_o      (funct3_o),
      .funct7_o      (funct7_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .instr_valid_o (instr_valid_o),
      .misalign_o    (misalign_o),
      .instret_o     (instret_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
   endtask

   // Model: instruction waiting to be fetched, instruction held for retire,
   // or the idle boot cycle.
   bit          m_booting;
   bit          m_holding;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   bit          m_mis;
   logic [31:0] m_cnt;

   task automatic model_step();
      if (reset) begin
         m_booting = 1; m_holding = 0; m_pc = RST_PC; m_instr = NOPV;
         m_mis = 0; m_cnt = 0;
      end else if (m_booting) begin
         m_booting = 0;
      end else if (!m_holding) begin
         if (imem_ready) begin
            m_instr   = imem_rdata;
            m_holding = 1;
         end
      end else if (retire_i) begin
         m_cnt = m_cnt + 1;
         if (branch_i || pc_update_i) begin
            m_pc = target_i & 32'hFFFF_FFFC;
            if (target_i % 4 != 0) m_mis = 1;
         end else begin
            m_pc = m_pc + 4;
         end
         m_holding = 0;
      end
   endtask

   task automatic check_all();
      chk("req",    {31'd0, imem_req}, {31'd0, !m_booting && !m_holding});
      chk("addr",   imem_addr, m_pc);
      chk("pc",     pc_o, m_pc);
      chk("pc4",    pc_plus4_o, m_pc + 32'd4);
      chk("instr",  instr_o, m_instr);
      chk("opcode", {25'd0, opcode_o}, {25'd0, m_instr[6:0]});
      chk("funct3", {29'd0, funct3_o}, {29'd0, m_instr[14:12]});
      chk("funct7", {25'd0, funct7_o}, {25'd0, m_instr[31:25]});
      chk("valid",  {31'd0, instr_valid_o}, {31'd0, m_holding});
      chk("mis",    {31'd0, misalign_o}, {31'd0, m_mis});
      chk("instret", instret_o, m_cnt);
   endtask

   task automatic cyc(input logic rst, input logic rdy, input logic [31:0] rdata,
                      input logic ret, input logic br, input logic pu,
                      input logic [31:0] tgt);
      reset = rst; imem_ready = rdy; imem_rdata = rdata;
      retire_i = ret; branch_i = br; pc_update_i = pu; target_i = tgt;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic fetch_now(input logic [31:0] rdata);
      cyc(0, 1, rdata, 0, 0, 0, 0);
   endtask

   task automatic retire(input logic br, input logic pu, input logic [31:0] tgt);
      cyc(0, 0, $urandom, 1, br, pu, tgt);
   endtask

   initial begin
      m_booting = 1; m_holding = 0; m_pc = RST_PC; m_instr = NOPV; m_mis = 0; m_cnt = 0;
      reset = 1; imem_ready = 0; imem_rdata = 0; retire_i = 0;
      branch_i = 0; pc_update_i = 0; target_i = 0;
      @(negedge clk);

      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_pc", pc_o, RST_PC);
      chk("rst_instr", instr_o, NOPV);

      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("boot_req", {31'd0, imem_req}, 32'd1);
      chk("boot_addr", imem_addr, 32'h0040_0000);

      // retire/branch ignored while fetching; two stall cycles
      cyc(0, 0, 0, 1, 1, 0, 32'h1234_5678);
      chk("ign_pc", pc_o, 32'h0040_0000);
      chk("ign_cnt", instret_o, 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      fetch_now(32'h0050_0093);
      chk("f_instr", instr_o, 32'h0050_0093);
      chk("f_op", {25'd0, opcode_o}, 32'h13);
      chk("f_valid", {31'd0, instr_valid_o}, 32'd1);
      retire(0, 0, 0);
      chk("seq_addr", imem_addr, 32'h0040_0004);
      chk("seq_cnt", instret_o, 32'd1);

      fetch_now($urandom);
      retire(1, 0, 32'h0040_0100);
      chk("br_pc", pc_o, 32'h0040_0100);
      chk("br_req", {31'd0, imem_req}, 32'd1);
      fetch_now($urandom);
      retire(0, 0, 32'h0000_0800);
      chk("nobr_pc", pc_o, 32'h0040_0104);

      fetch_now($urandom);
      retire(0, 1, 32'h0040_0102);
      chk("mis_pc", pc_o, 32'h0040_0100);
      chk("mis_set", {31'd0, misalign_o}, 32'd1);
      fetch_now($urandom);
      retire(1, 1, 32'h0040_0200);
      chk("both_pc", pc_o, 32'h0040_0200);
      chk("mis_sticky", {31'd0, misalign_o}, 32'd1);

      fetch_now($urandom);
      retire(1, 0, 32'hFFFF_FFFC);
      fetch_now($urandom);
      retire(0, 0, 0);
      chk("wrap_pc", pc_o, 32'h0000_0000);

      // reset mid-fetch, including a response arriving with reset
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
      chk("mrst_req", {31'd0, imem_req}, 32'd0);
      chk("mrst_pc", pc_o, RST_PC);
      chk("mrst_cnt", instret_o, 32'd0);
      chk("mrst_instr", instr_o, NOPV);
      chk("mrst_mis", {31'd0, misalign_o}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), $urandom,
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) == 0), t);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
